// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - multi-cycle data-memory responder with pipeline stall
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2,
  parameter int TEST_ADDR   = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_we,
  input  logic        req_re,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        misalign_err,
  output logic [15:0] test_value
);

  localparam int            AW       = $clog2(DEPTH_WORDS);
  localparam bit            ZERO_LAT = (LATENCY == 0);
  localparam logic [3:0]    CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic [AW-1:0] TEST_IDX = AW'((TEST_ADDR / 4) % DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic          cap_we;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req;
  logic          do_access;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          acc_mis;
  logic          unused_addr_hi;

  assign req   = req_we | req_re;
  assign stall = ((state == S_IDLE) && req) || (state == S_BUSY);

  // Select the access operands: with zero latency the access happens on the
  // same edge that accepts the request, so the live inputs are used.
  always_comb begin
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_we    = cap_we;
    do_access = 1'b0;
    if (state == S_IDLE) begin
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_we    = req_we;
      do_access = req && ZERO_LAT;
    end else if (state == S_BUSY) begin
      do_access = (cnt == 4'd0);
    end
  end

  assign acc_idx        = acc_addr[AW+1:2];
  assign acc_mis        = |acc_addr[1:0];
  assign unused_addr_hi = ^acc_addr[31:AW+2];
  assign test_value     = mem[TEST_IDX][15:0];

  // Sequencer: accept a request in IDLE, count wait cycles, pulse completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= 4'd0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_we       <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      rd_valid     <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cap_we    <= req_we;
            if (ZERO_LAT) begin
              state <= S_DONE;
            end else begin
              state <= S_BUSY;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_BUSY: begin
          if (cnt == 4'd0) state <= S_DONE;
          else             cnt   <= cnt - 4'd1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (do_access) begin
        rd_valid     <= 1'b1;
        misalign_err <= acc_mis;
        if (acc_mis)      rd_data <= '0;
        else if (!acc_we) rd_data <= mem[acc_idx];
      end
    end
  end

  // Storage array: cleared on reset, written only by aligned stores.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (do_access && acc_we && !acc_mis) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;

  logic        clk;
  logic        reset;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_we;
  logic        req_re;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        misalign_err;
  logic [15:0] test_value;

  int n_tests;
  int n_fail;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_rd;

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT),
    .TEST_ADDR  (0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_we      (req_we),
    .req_re      (req_re),
    .stall       (stall),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .misalign_err(misalign_err),
    .test_value  (test_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_rd = '0;
  endtask

  // One request: drive for a single cycle, scramble inputs afterwards, and
  // check stall/rd_valid cycle by cycle against the expected latency.
  task automatic run_req(input logic we, input logic re, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag);
    logic exp_mis;
    int   idx;
    exp_mis = (addr % 4) != 0;
    idx     = int'((addr / 4) % DEPTH);
    if (exp_mis)  model_rd = '0;
    else if (we)  model_mem[idx] = wdata;
    else          model_rd = model_mem[idx];

    @(negedge clk);
    req_we = we; req_re = re; req_addr = addr; req_wdata = wdata;
    #1;
    check({tag, "_stall_req"}, stall, 1);
    @(negedge clk);
    req_we = 0; req_re = 0; req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= LAT; c++) begin
      #1;
      check({tag, "_stall_busy"}, stall, 1);
      check({tag, "_valid_early"}, rd_valid, 0);
      @(negedge clk);
    end
    #1;
    check({tag, "_valid"}, rd_valid, 1);
    check({tag, "_stall_done"}, stall, 0);
    check({tag, "_misalign"}, misalign_err, exp_mis);
    check({tag, "_rd_data"}, rd_data, model_rd);
    check({tag, "_test_value"}, test_value, model_mem[0][15:0]);
    @(negedge clk);
    #1;
    check({tag, "_valid_after"}, rd_valid, 0);
    check({tag, "_mis_after"}, misalign_err, 0);
  endtask

  initial begin
    logic        we;
    logic        re;
    logic [31:0] addr;
    n_tests = 0;
    n_fail  = 0;
    reset = 1; req_we = 0; req_re = 0; req_addr = 0; req_wdata = 0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("rst_stall", stall, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_test_value", test_value, 0);

    run_req(0, 1, 32'h10, 32'h0, "t1_load10");
    run_req(1, 0, 32'h0, 32'hDEADBEEF, "t2_store0");
    run_req(0, 1, 32'h0, 32'h0, "t3_load0");
    run_req(1, 0, 32'h102, 32'h12345678, "t4_mis");
    run_req(1, 0, 32'h100, 32'h12345678, "t4_wrap");
    run_req(1, 1, 32'h8, 32'hA5, "t5_both");
    run_req(0, 1, 32'h8, 32'h0, "t5_load8");

    // Reset during BUSY aborts the pending store and clears memory.
    @(negedge clk);
    req_we = 1; req_addr = 32'h4; req_wdata = 32'h77;
    @(negedge clk);
    req_we = 0;
    #1;
    check("t6_stall_busy", stall, 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    #1;
    check("t6_stall", stall, 0);
    check("t6_valid", rd_valid, 0);
    check("t6_test_value", test_value, 0);
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      #1;
      check("t6_no_complete", rd_valid, 0);
    end
    run_req(0, 1, 32'h4, 32'h0, "t6_load4");

    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom_range(0, 1));
      re   = we ? 1'($urandom_range(0, 1)) : 1'b1;
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      if ($urandom_range(0, 1) != 0) addr[31:10] = '0;
      run_req(we, re, addr, $urandom, "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
